risc8_mem_arbiter: RTL
======================

Name: risc8_mem_arbiter

Overview:
Shares the single 16-bit-data / 24-bit-address memory port between the risc8 instruction-fetch path (pc) and the datapath data path (loads, stores, stack push/pop).
- Sits between the core and the memory macro.
- Serialises one outstanding access at a time.
- Returns read data to the owner.
- Exports a stall so the control unit can hold the pipeline.
- Data has priority. A starvation counter guarantees fetch forward progress.

Parameters:
AW, 24, memory address width
DW, 16, memory data width
MEM_LAT, 1, cycles from address presented to m_rdata valid (1..7)
STARVE_MAX, 4, consecutive data grants allowed while fetch is pending before fetch is forced

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
f_req  in  1  fetch request
f_addr  in  16  fetch address (pc); mapped to memory address {8'h00, f_addr}
f_gnt  out  1  fetch accepted this cycle
f_rvalid  out  1  fetch data valid
f_rdata  out  16  fetch read data
d_req  in  1  data request
d_we  in  1  data write enable
d_addr  in  AW  data address
d_wdata  in  DW  data write value
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  data read data valid / write complete
d_rdata  out  DW  data read data
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_we  out  1  memory write strobe
m_rdata  in  DW  memory read data
stall  out  1  a request is pending and not granted this cycle, or a response is outstanding

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous, active-high.
- Reset state:
  - FSM in IDLE; starve counter = 0; owner = none.
  - f_gnt, d_gnt, f_rvalid, d_rvalid, m_we, stall = 0.
  - m_addr, m_wdata = 0.
  - f_rdata, d_rdata = 0.
- FSM states:
  - IDLE: no access outstanding.
  - BUSY: latency counter running, lat_cnt counts 0..MEM_LAT-1.
- Arbitration, evaluated in IDLE, or in BUSY on the response cycle:
  - If d_req and not (f_req and starve == STARVE_MAX), grant data.
  - Else if f_req, grant fetch.
- Grant cycle:
  - x_gnt = 1 combinationally.
  - m_addr, m_wdata and m_we (= d_we for data, 0 for fetch) are driven combinationally from the winner.
  - At the clock edge: owner and we are registered, lat_cnt = 0, go to BUSY.
- Outside the grant cycle:
  - m_addr and m_wdata hold their last registered values.
  - m_we = 0.
- Response cycle:
  - Occurs when BUSY and lat_cnt == MEM_LAT-1, i.e. MEM_LAT cycles after the grant cycle.
  - Owner's x_rvalid = 1 for exactly one cycle; x_rdata = m_rdata, registered into x_rdata at that edge and held until the next response.
  - For writes, d_rvalid pulses with d_rdata unchanged.
  - A new grant is permitted in the response cycle. This gives one access per MEM_LAT+0 cycles back-to-back (MEM_LAT=1: one per cycle).
  - With no new grant, return to IDLE.
- Requester rules:
  - x_req, x_addr and x_wdata stay stable until x_gnt.
  - A requester has at most one access outstanding.
  - A request asserted while that requester's response is pending is arbitrated normally; it is legal because only one owner exists.
- Starve counter:
  - Increments on each data grant while f_req = 1, saturating at STARVE_MAX.
  - Clears on any fetch grant, or when f_req = 0.
- stall = (f_req & ~f_gnt) | (d_req & ~d_gnt) | (BUSY & ~response cycle).
- Simultaneous requests in the same cycle: exactly one gnt; the loser keeps its req and is served no earlier than the next arbitration point.
- Reset mid-transaction:
  - The outstanding response is discarded; no rvalid is ever produced for it.
  - The FSM returns to IDLE immediately (asynchronous).
- STARVE_MAX = 0: fetch always wins a tie.

Decomposition:
- Shared package risc8_pkg gets:
  - typedef mem_owner_t {OWN_NONE, OWN_FETCH, OWN_DATA}.
  - typedef arb_state_t {ARB_IDLE, ARB_BUSY}.
  - Constant FETCH_PAGE = 8'h00.
- One natural sub-module: risc8_arb_prio, the combinational priority/starvation select with the saturating starve register. It is instantiated once.

Test Plan:
- Fetch only, MEM_LAT=1, f_addr 16'h0102:
  - m_addr = 24'h000102 and f_gnt in cycle 0.
  - f_rvalid with f_rdata = m_rdata (16'hBEEF) in cycle 1.
  - stall = 0 throughout.
- Simultaneous f_req and d_req, d_addr 24'hFF8FFF, d_we=1, d_wdata 16'h00AA:
  - d_gnt and m_we = 1 in cycle 0; d_rvalid in cycle 1.
  - f_gnt in cycle 1.
- d_req held continuously with f_req = 1, STARVE_MAX=4:
  - Data grants in cycles 0–3, fetch granted in cycle 4.
  - Counter back to 0 afterwards.
- MEM_LAT=3, back-to-back data reads:
  - Grants in cycles 0 and 3; d_rvalid in cycles 3 and 6.
  - stall = 1 in cycles 1–2 and 4–5.
- rst asserted in cycle 1 of a MEM_LAT=3 fetch:
  - All outputs 0 immediately; no f_rvalid is ever produced.
  - A new f_req after reset release is granted in its first cycle.
- Write followed by read to the same address 24'h001234 against a memory model:
  - d_rdata returns the written value 16'h5A5A.
  - m_we = 1 only in the write grant cycle.

Source files
------------

// File: rtl/risc8_pkg.sv
// Shared types and constants for the risc8 memory-port arbiter.
package risc8_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DATA
    } mem_owner_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // Instruction fetches live in the lowest 64K page of the 24-bit space.
    localparam logic [7:0] FETCH_PAGE = 8'h00;

endpackage

// File: rtl/risc8_arb_prio.sv
// Data-first priority select with a saturating starvation counter that
// forces a fetch grant after STARVE_MAX consecutive data wins.
module risc8_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic f_req,
    input  logic d_req,
    output logic f_win,
    output logic d_win
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        d_win    = arb_en & d_req & ~(f_req & (starve_q == SMAX));
        f_win    = arb_en & f_req & ~d_win;
        starve_d = starve_q;
        // Only data wins that actually delay a waiting fetch count as starvation.
        if (!f_req || f_win) begin
            starve_d = '0;
        end else if (d_win && (starve_q != SMAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/risc8_mem_arbiter.sv
// Single-outstanding arbiter sharing the risc8 memory port between
// instruction fetch and the datapath; data wins unless fetch is starving.
module risc8_mem_arbiter
    import risc8_pkg::*;
#(
    parameter int AW         = 24,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [15:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [15:0]   f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    input  logic [DW-1:0] m_rdata,
    output logic          stall
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    arb_state_t    state_q, state_d;
    mem_owner_t    owner_q, owner_d;
    logic          we_q, we_d;
    logic [2:0]    lat_cnt_q, lat_cnt_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [15:0]   f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic busy, resp_cyc, arb_en, f_win, d_win;

    assign busy     = (state_q == ARB_BUSY);
    assign resp_cyc = busy & (lat_cnt_q == LAT_LAST);
    // Reset also masks the combinational grant path so every output is 0 while rst is high.
    assign arb_en   = ~rst & (~busy | resp_cyc);

    risc8_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk   (clk),
        .rst   (rst),
        .arb_en(arb_en),
        .f_req (f_req),
        .d_req (d_req),
        .f_win (f_win),
        .d_win (d_win)
    );

    always_comb begin
        f_gnt    = f_win;
        d_gnt    = d_win;
        m_we     = d_win & d_we;
        m_addr   = m_addr_q;
        m_wdata  = m_wdata_q;
        if (d_win) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (f_win) begin
            m_addr  = AW'({FETCH_PAGE, f_addr});
        end
        f_rvalid = resp_cyc & (owner_q == OWN_FETCH);
        d_rvalid = resp_cyc & (owner_q == OWN_DATA);
        f_rdata  = f_rvalid ? 16'(m_rdata) : f_rdata_q;
        d_rdata  = (d_rvalid & ~we_q) ? m_rdata : d_rdata_q;
        stall    = ~rst & ((f_req & ~f_win) | (d_req & ~d_win) | (busy & ~resp_cyc));
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        lat_cnt_d = lat_cnt_q;
        m_addr_d  = m_addr;
        m_wdata_d = m_wdata;
        f_rdata_d = f_rdata;
        d_rdata_d = d_rdata;
        // A grant in the response cycle chains straight into the next access.
        if (f_win || d_win) begin
            state_d   = ARB_BUSY;
            owner_d   = d_win ? OWN_DATA : OWN_FETCH;
            we_d      = m_we;
            lat_cnt_d = '0;
        end else if (resp_cyc) begin
            state_d   = ARB_IDLE;
            owner_d   = OWN_NONE;
            we_d      = 1'b0;
            lat_cnt_d = '0;
        end else if (busy) begin
            lat_cnt_d = lat_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_NONE;
            we_q      <= 1'b0;
            lat_cnt_q <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            lat_cnt_q <= lat_cnt_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule
